// File: rtl/floating_point_multiplier_pipe.sv
// Three-stage IEEE-style floating-point multiplier.
// S1 unpacks and classifies, S2 multiplies significands, S3 normalises,
// rounds to nearest-even, packs and raises overflow/underflow/invalid.
// Subnormal operands are treated as signed zero; NaN results are canonical.
module floating_point_multiplier_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);

  localparam int DATA_WIDTH = 1 + EXP_W + MAN_W;
  localparam int BIAS       = 2**(EXP_W-1) - 1;
  localparam int PW         = 2*MAN_W + 2;
  // Signed exponent width: headroom for sum, normalise and rounding carry
  localparam int ESW        = EXP_W + 2;

  localparam logic [ESW-1:0]        BIAS_V  = ESW'(BIAS);
  localparam logic [ESW-1:0]        EXP_MAX = ESW'(2**EXP_W - 1);
  localparam logic [DATA_WIDTH-1:0] NAN_PAT =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  // Stage 1 registers
  logic             s1_valid;
  logic             s1_sign;
  logic [ESW-1:0]   s1_exp;
  logic [MAN_W:0]   s1_ma;
  logic [MAN_W:0]   s1_mb;
  cls_t             s1_cls;
  logic             s1_inv;

  // Stage 2 registers
  logic             s2_valid;
  logic             s2_sign;
  logic [ESW-1:0]   s2_exp;
  logic [PW-1:0]    s2_prod;
  cls_t             s2_cls;
  logic             s2_inv;

  // Stage 1 combinational unpack/classify
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  cls_t             cls_d;
  logic             inv_d;

  // Split operands and classify the pair into a special-case class
  always_comb begin
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (ma == '0);
    b_inf  = (eb == '1) && (mb == '0);
    a_nan  = (ea == '1) && (ma != '0);
    b_nan  = (eb == '1) && (mb != '0);
    cls_d  = CLS_NORM;
    inv_d  = 1'b0;
    if (a_nan || b_nan) begin
      cls_d = CLS_NAN;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      cls_d = CLS_NAN;
      inv_d = 1'b1;
    end else if (a_inf || b_inf) begin
      cls_d = CLS_INF;
    end else if (a_zero || b_zero) begin
      cls_d = CLS_ZERO;
    end
  end

  // S1: capture sign, biased exponent sum, significands with hidden bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_ma    <= '0;
      s1_mb    <= '0;
      s1_cls   <= CLS_NORM;
      s1_inv   <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= sa ^ sb;
      s1_exp   <= {2'b00, ea} + {2'b00, eb} - BIAS_V;
      s1_ma    <= {1'b1, ma};
      s1_mb    <= {1'b1, mb};
      s1_cls   <= cls_d;
      s1_inv   <= inv_d;
    end
  end

  // S2: full-width significand product
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_exp   <= '0;
      s2_prod  <= '0;
      s2_cls   <= CLS_NORM;
      s2_inv   <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_exp   <= s1_exp;
      s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
      s2_cls   <= s1_cls;
      s2_inv   <= s1_inv;
    end
  end

  // Stage 3 combinational normalise/round/pack
  logic [PW-2:0]         norm;
  logic [MAN_W-1:0]      frac;
  logic                  g, r, st, lsb, rup;
  logic [MAN_W:0]        frac_r;
  logic [ESW-1:0]        exp_f;
  logic                  ov_cond, uf_cond;
  logic [DATA_WIDTH-1:0] res_d;
  logic                  ov_d, uf_d, inv_o_d;

  // Normalise so the hidden bit sits just above norm, then round-to-nearest-even
  always_comb begin
    norm    = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
    frac    = norm[PW-2 -: MAN_W];
    lsb     = norm[MAN_W+1];
    g       = norm[MAN_W];
    r       = norm[MAN_W-1];
    st      = |norm[MAN_W-2:0];
    rup     = g & (r | st | lsb);
    frac_r  = {1'b0, frac} + (MAN_W+1)'(rup);
    exp_f   = s2_exp + ESW'(s2_prod[PW-1]) + ESW'(frac_r[MAN_W]);
    ov_cond = $signed(exp_f) >= $signed(EXP_MAX);
    uf_cond = exp_f[ESW-1] || (exp_f == '0);
    res_d   = {s2_sign, {(DATA_WIDTH-1){1'b0}}};
    ov_d    = 1'b0;
    uf_d    = 1'b0;
    inv_o_d = 1'b0;
    case (s2_cls)
      CLS_NAN: begin
        res_d   = NAN_PAT;
        inv_o_d = s2_inv;
      end
      CLS_INF:  res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: res_d = {s2_sign, {(DATA_WIDTH-1){1'b0}}};
      default: begin
        if (ov_cond) begin
          res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ov_d  = 1'b1;
        end else if (uf_cond) begin
          res_d = {s2_sign, {(DATA_WIDTH-1){1'b0}}};
          uf_d  = 1'b1;
        end else begin
          // On rounding carry frac_r low bits are already zero
          res_d = {s2_sign, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
        end
      end
    endcase
  end

  // S3: output register, result/flags only load for a valid entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result    <= res_d;
        overflow  <= ov_d;
        underflow <= uf_d;
        invalid   <= inv_o_d;
      end
    end
  end

endmodule

// File: tb/tb_floating_point_multiplier_pipe.sv
// Bench for floating_point_multiplier_pipe: half-precision vector table
// scored through a queue, stall/reset sequences, and a single-precision check.
`timescale 1ns/1ps
module tb_floating_point_multiplier_pipe;

  logic        clk = 1'b0;
  logic        reset, en, in_valid;
  logic [15:0] a, b, result;
  logic        out_valid, overflow, underflow, invalid;

  logic        in_valid32;
  logic [31:0] a32, b32, result32;
  logic        out_valid32, overflow32, underflow32, invalid32;

  always #5 clk = ~clk;

  floating_point_multiplier_pipe dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .overflow(overflow),
    .underflow(underflow), .invalid(invalid)
  );

  floating_point_multiplier_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid32), .a(a32), .b(b32),
    .out_valid(out_valid32), .result(result32), .overflow(overflow32),
    .underflow(underflow32), .invalid(invalid32)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [2:0]  flags;   // {overflow, underflow, invalid}
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  flags;
  } exp_t;

  localparam int NV = 20;
  vec_t vecs [NV];
  exp_t exp_q [$];
  int   due_q [$];

  int checks   = 0;
  int failures = 0;
  int ecyc     = 0;

  logic mon_en, mon_iv, mon_rst;
  exp_t mon_e;
  int   mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: on every enabled edge record sample times, pop and compare outputs
  always @(posedge clk) begin
    mon_en  = en;
    mon_iv  = in_valid;
    mon_rst = reset;
    #1;
    if (!mon_rst && mon_en) begin
      ecyc++;
      if (mon_iv) due_q.push_back(ecyc + 2);
      if (out_valid) begin
        if (exp_q.size() == 0 || due_q.size() == 0) begin
          check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_d = due_q.pop_front();
          check("latency", ecyc, mon_d);
          check("result", {16'd0, result}, {16'd0, mon_e.res});
          check("flags", {29'd0, overflow, underflow, invalid}, {29'd0, mon_e.flags});
        end
      end
    end
  end

  task automatic drive(input logic [15:0] ta, input logic [15:0] tb, input logic [15:0] tres,
                       input logic [2:0] tfl);
    exp_t e;
    e.res   = tres;
    e.flags = tfl;
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{16'h4200, 16'hC600, 16'hCC80, 3'b000};
    vecs[1]  = '{16'h3C00, 16'h4000, 16'h4000, 3'b000};
    vecs[2]  = '{16'h3C01, 16'h3C01, 16'h3C02, 3'b000};
    vecs[3]  = '{16'h7BFF, 16'h4000, 16'h7C00, 3'b100};
    vecs[4]  = '{16'h7C00, 16'h0000, 16'h7E00, 3'b001};
    vecs[5]  = '{16'h0400, 16'h3800, 16'h0000, 3'b010};
    vecs[6]  = '{16'h7E00, 16'h3C00, 16'h7E00, 3'b000};
    vecs[7]  = '{16'hFC00, 16'h4000, 16'hFC00, 3'b000};
    vecs[8]  = '{16'h8000, 16'h4500, 16'h8000, 3'b000};
    vecs[9]  = '{16'h0001, 16'h3C00, 16'h0000, 3'b000};
    vecs[10] = '{16'h7C00, 16'hFC00, 16'hFC00, 3'b000};
    vecs[11] = '{16'h7E00, 16'h0000, 16'h7E00, 3'b000};
    vecs[12] = '{16'h3C01, 16'h3E00, 16'h3E02, 3'b000};
    vecs[13] = '{16'h3C03, 16'h3E00, 16'h3E04, 3'b000};
    vecs[14] = '{16'h3FFE, 16'h3C01, 16'h4000, 3'b000};
    vecs[15] = '{16'h0400, 16'h3C00, 16'h0400, 3'b000};
    vecs[16] = '{16'h7BFF, 16'h3C00, 16'h7BFF, 3'b000};
    vecs[17] = '{16'h8400, 16'h3800, 16'h8000, 3'b010};
    vecs[18] = '{16'h0000, 16'hFC00, 16'h7E00, 3'b001};
    vecs[19] = '{16'h83FF, 16'h4000, 16'h8000, 3'b000};

    reset = 1'b1; en = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    in_valid32 = 1'b0; a32 = '0; b32 = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_flags", {29'd0, overflow, underflow, invalid}, 32'd0);
    check("rst_out_valid32", {31'd0, out_valid32}, 32'd0);
    check("rst_result32", result32, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back table vectors, one per cycle
    for (int i = 0; i < NV; i++) drive(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags);
    in_valid = 1'b0;
    drain();
    repeat (2) @(negedge clk);

    // Stall: P1 at output, P2 in S2, then 4 disabled cycles
    drive(16'h3C00, 16'h4000, 16'h4000, 3'b000);
    drive(16'h4200, 16'hC600, 16'hCC80, 3'b000);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_stall_valid", {31'd0, out_valid}, 32'd1);
    check("pre_stall_result", {16'd0, result}, 32'h4000);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_valid_hold", {31'd0, out_valid}, 32'd1);
      check("stall_result_hold", {16'd0, result}, 32'h4000);
    end
    en = 1'b1;
    @(negedge clk);
    check("post_stall_valid", {31'd0, out_valid}, 32'd1);
    check("post_stall_result", {16'd0, result}, 32'hCC80);
    @(negedge clk);
    check("post_stall_idle", {31'd0, out_valid}, 32'd0);
    drain();

    // Asynchronous reset pulse with two pairs still in flight
    drive(16'h3C00, 16'h4000, 16'h4000, 3'b000);
    drive(16'h4200, 16'hC600, 16'hCC80, 3'b000);
    drive(16'h7BFF, 16'h4000, 16'h7C00, 3'b100);
    in_valid = 1'b0;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_result", {16'd0, result}, 32'd0);
    check("async_rst_flags", {29'd0, overflow, underflow, invalid}, 32'd0);
    exp_q.delete();
    due_q.delete();
    #3 reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale_valid", {31'd0, out_valid}, 32'd0);
    end
    drive(16'h7C00, 16'h0000, 16'h7E00, 3'b001);
    in_valid = 1'b0;
    drain();

    // Single-precision instance: 3.0 * -6.0
    @(negedge clk);
    a32 = 32'h40400000; b32 = 32'hC0C00000; in_valid32 = 1'b1;
    @(negedge clk);
    in_valid32 = 1'b0;
    check("sp_early1", {31'd0, out_valid32}, 32'd0);
    @(negedge clk);
    check("sp_early2", {31'd0, out_valid32}, 32'd0);
    @(negedge clk);
    check("sp_valid", {31'd0, out_valid32}, 32'd1);
    check("sp_result", result32, 32'hC1900000);
    check("sp_flags", {29'd0, overflow32, underflow32, invalid32}, 32'd0);
    @(negedge clk);
    check("sp_idle", {31'd0, out_valid32}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
